// File: rtl/mesa_pkg.sv
// Shared constants, FSM states and helpers for the Mesa Wi nibble decoder.
package mesa_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [BYTE_W-1:0] PREAMBLE   = 8'hF0;
  localparam logic [BYTE_W-1:0] BCAST_SLOT = 8'hFF;
  localparam logic [BYTE_W-1:0] NULL_SLOT  = 8'hFE;

  typedef enum logic [2:0] {
    HUNT,
    SLOT,
    SUB,
    LEN,
    PAYLOAD
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] subslot;
    logic [BYTE_W-1:0] len;
  } loc_hdr_t;

  // Slot 0 is ours and becomes NULL; broadcast and NULL pass through; others count down.
  function automatic logic [BYTE_W-1:0] slot_rewrite(input logic [BYTE_W-1:0] s);
    if (s == BCAST_SLOT || s == NULL_SLOT) return s;
    else if (s == '0)                      return NULL_SLOT;
    else                                   return s - BYTE_W'(1);
  endfunction

  function automatic logic slot_is_local(input logic [BYTE_W-1:0] s);
    return (s == '0) || (s == BCAST_SLOT);
  endfunction

endpackage

// File: rtl/mesa_nib_decode_if.sv
// Wi nibble input, Wo byte output and local Mesa-Bus strobe stream of the decoder.
interface mesa_nib_decode_if;
  import mesa_pkg::*;

  logic              mesa_wi_flush;
  logic              mesa_wi_nib_en;
  logic [NIB_W-1:0]  mesa_wi_nib_d;
  logic              mesa_wo_byte_en;
  logic [BYTE_W-1:0] mesa_wo_byte_d;
  logic              mesa_wo_busy;
  logic              wo_overrun;
  logic              rx_loc_start;
  logic [BYTE_W-1:0] rx_loc_subslot;
  logic [BYTE_W-1:0] rx_loc_len;
  logic              rx_byte_en;
  logic [BYTE_W-1:0] rx_byte_d;
  logic              rx_loc_stop;
  logic              rx_loc_abort;

  modport slave (
    input  mesa_wi_flush, mesa_wi_nib_en, mesa_wi_nib_d, mesa_wo_busy,
    output mesa_wo_byte_en, mesa_wo_byte_d, wo_overrun,
    output rx_loc_start, rx_loc_subslot, rx_loc_len,
    output rx_byte_en, rx_byte_d, rx_loc_stop, rx_loc_abort
  );

  modport master (
    output mesa_wi_flush, mesa_wi_nib_en, mesa_wi_nib_d, mesa_wo_busy,
    input  mesa_wo_byte_en, mesa_wo_byte_d, wo_overrun,
    input  rx_loc_start, rx_loc_subslot, rx_loc_len,
    input  rx_byte_en, rx_byte_d, rx_loc_stop, rx_loc_abort
  );

endinterface

// File: rtl/mesa_nib2byte.sv
// Pairs Wi nibbles into bytes; while resync is high it slides a 2-nibble window
// looking for the preamble, which fixes the byte phase.
module mesa_nib2byte
  import mesa_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              nib_en,
  input  logic [NIB_W-1:0]  nib_d,
  input  logic              resync,
  output logic              byte_en_c,
  output logic [BYTE_W-1:0] byte_d_c,
  output logic              sof_c
);

  logic [NIB_W-1:0] hi_q, hi_d;
  logic             have_hi_q, have_hi_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q      <= '0;
      have_hi_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      have_hi_q <= have_hi_d;
    end
  end

  // Flush wins over a coincident strobe and drops any half byte.
  always_comb begin
    hi_d      = hi_q;
    have_hi_d = have_hi_q;
    byte_en_c = 1'b0;
    sof_c     = 1'b0;
    byte_d_c  = {hi_q, nib_d};
    if (flush) begin
      hi_d      = '0;
      have_hi_d = 1'b0;
    end else if (nib_en) begin
      if (resync) begin
        if (have_hi_q && byte_d_c == PREAMBLE) begin
          byte_en_c = 1'b1;
          sof_c     = 1'b1;
          have_hi_d = 1'b0;
        end else begin
          hi_d      = nib_d;
          have_hi_d = 1'b1;
        end
      end else if (!have_hi_q) begin
        hi_d      = nib_d;
        have_hi_d = 1'b1;
      end else begin
        byte_en_c = 1'b1;
        have_hi_d = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mesa_nib_decode.sv
// Mesa Wi decoder: parses packet headers, forwards bytes on Wo with slot
// rewrite, and delivers local/broadcast packets to the Mesa-Bus core.
module mesa_nib_decode
  import mesa_pkg::*;
(
  input logic              clk,
  input logic              reset_n,
  mesa_nib_decode_if.slave bus
);

  logic              byte_en_c, sof_c;
  logic [BYTE_W-1:0] byte_d_c;
  logic [BYTE_W-1:0] fwd_byte_c;

  state_t            state_q, state_d;
  logic              local_q, local_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] sub_q, sub_d;
  loc_hdr_t          hdr_q, hdr_d;
  logic              wo_en_q, wo_en_d;
  logic [BYTE_W-1:0] wo_byte_d_q, wo_byte_d_d;
  logic              overrun_q, overrun_d;
  logic              start_q, start_d;
  logic              rx_en_q, rx_en_d;
  logic [BYTE_W-1:0] rx_byte_d_q, rx_byte_d_d;
  logic              stop_q, stop_d;
  logic              abort_q, abort_d;

  mesa_nib2byte u_nib2byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (bus.mesa_wi_flush),
    .nib_en    (bus.mesa_wi_nib_en),
    .nib_d     (bus.mesa_wi_nib_d),
    .resync    (state_q == HUNT),
    .byte_en_c (byte_en_c),
    .byte_d_c  (byte_d_c),
    .sof_c     (sof_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      local_q     <= 1'b0;
      cnt_q       <= '0;
      sub_q       <= '0;
      hdr_q       <= '0;
      wo_en_q     <= 1'b0;
      wo_byte_d_q <= '0;
      overrun_q   <= 1'b0;
      start_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      rx_byte_d_q <= '0;
      stop_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      local_q     <= local_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      hdr_q       <= hdr_d;
      wo_en_q     <= wo_en_d;
      wo_byte_d_q <= wo_byte_d_d;
      overrun_q   <= overrun_d;
      start_q     <= start_d;
      rx_en_q     <= rx_en_d;
      rx_byte_d_q <= rx_byte_d_d;
      stop_q      <= stop_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    local_d     = local_q;
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    hdr_d       = hdr_q;
    wo_en_d     = 1'b0;
    wo_byte_d_d = wo_byte_d_q;
    overrun_d   = overrun_q;
    start_d     = 1'b0;
    rx_en_d     = 1'b0;
    rx_byte_d_d = rx_byte_d_q;
    stop_d      = 1'b0;
    abort_d     = 1'b0;
    fwd_byte_c  = byte_d_c;
    if (bus.mesa_wi_flush) begin
      // Only a delivery already announced by rx_loc_start needs an abort.
      state_d = HUNT;
      abort_d = (state_q == PAYLOAD) && local_q;
    end else if (byte_en_c) begin
      case (state_q)
        HUNT: if (sof_c) state_d = SLOT;
        SLOT: begin
          fwd_byte_c = slot_rewrite(byte_d_c);
          local_d    = slot_is_local(byte_d_c);
          state_d    = SUB;
        end
        SUB: begin
          sub_d   = byte_d_c;
          state_d = LEN;
        end
        LEN: begin
          if (local_q) begin
            start_d = 1'b1;
            hdr_d   = '{subslot: sub_q, len: byte_d_c};
          end
          if (byte_d_c == '0) begin
            stop_d  = local_q;
            state_d = HUNT;
          end else begin
            cnt_d   = CNT_W'(byte_d_c);
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (local_q) begin
            rx_en_d     = 1'b1;
            rx_byte_d_d = byte_d_c;
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            stop_d  = local_q;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
      // A busy Wo stage loses the byte but local delivery carries on.
      if (bus.mesa_wo_busy) begin
        overrun_d = 1'b1;
      end else begin
        wo_en_d     = 1'b1;
        wo_byte_d_d = fwd_byte_c;
      end
    end
  end

  assign bus.mesa_wo_byte_en = wo_en_q;
  assign bus.mesa_wo_byte_d  = wo_byte_d_q;
  assign bus.wo_overrun      = overrun_q;
  assign bus.rx_loc_start    = start_q;
  assign bus.rx_loc_subslot  = hdr_q.subslot;
  assign bus.rx_loc_len      = hdr_q.len;
  assign bus.rx_byte_en      = rx_en_q;
  assign bus.rx_byte_d       = rx_byte_d_q;
  assign bus.rx_loc_stop     = stop_q;
  assign bus.rx_loc_abort    = abort_q;

endmodule

// File: tb/tb_mesa_nib_decode.sv
// Directed bench for mesa_nib_decode: a packet-level model predicts every
// per-byte output event, checked each cycle, plus literal spot checks.
module tb_mesa_nib_decode;
  import mesa_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mesa_nib_decode_if bus ();

  mesa_nib_decode dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic       wo_en;
    logic [7:0] wo_d;
    logic       ovr;
    logic       start;
    logic [7:0] sub;
    logic [7:0] len;
    logic       rx_en;
    logic [7:0] rx_d;
    logic       stop;
    logic       abort;
  } rec_t;

  rec_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       m_ovr;
  logic [7:0] m_sub, m_len;
  logic [7:0] pk[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] exp_slot(input logic [7:0] s);
    case (s)
      8'hFF:   return 8'hFF;
      8'hFE:   return 8'hFE;
      8'h00:   return 8'hFE;
      default: return s - 8'd1;
    endcase
  endfunction

  // Per-byte expected events for one packet; n_del bytes reach the DUT before any flush.
  task automatic model_pkt(input logic [7:0] b[$], input int busy_idx, input int n_del);
    rec_t r;
    logic loc;
    int   len;
    loc = (b[1] == 8'h00) || (b[1] == 8'hFF);
    len = int'(b[3]);
    for (int i = 0; i < n_del; i++) begin
      r = '0;
      if (i == busy_idx) m_ovr = 1'b1;
      else begin
        r.wo_en = 1'b1;
        r.wo_d  = (i == 1) ? exp_slot(b[1]) : b[i];
      end
      if (i == 3 && loc) begin
        r.start = 1'b1;
        m_sub   = b[2];
        m_len   = b[3];
        r.stop  = (len == 0);
      end
      if (i >= 4 && loc) begin
        r.rx_en = 1'b1;
        r.rx_d  = b[i];
        r.stop  = (i == 3 + len);
      end
      r.ovr = m_ovr; r.sub = m_sub; r.len = m_len;
      if (r.wo_en || r.start || r.rx_en || r.stop) exp_q.push_back(r);
    end
    if (n_del < b.size() && loc && n_del >= 4) begin
      r = '0;
      r.abort = 1'b1;
      r.ovr = m_ovr; r.sub = m_sub; r.len = m_len;
      exp_q.push_back(r);
    end
  endtask

  task automatic compare_cycle();
    rec_t a, e;
    if (reset_n && (bus.mesa_wo_byte_en || bus.rx_loc_start || bus.rx_byte_en ||
                    bus.rx_loc_stop || bus.rx_loc_abort)) begin
      a.wo_en = bus.mesa_wo_byte_en;
      a.wo_d  = bus.mesa_wo_byte_en ? bus.mesa_wo_byte_d : 8'h00;
      a.ovr   = bus.wo_overrun;
      a.start = bus.rx_loc_start;
      a.sub   = bus.rx_loc_subslot;
      a.len   = bus.rx_loc_len;
      a.rx_en = bus.rx_byte_en;
      a.rx_d  = bus.rx_byte_en ? bus.rx_byte_d : 8'h00;
      a.stop  = bus.rx_loc_stop;
      a.abort = bus.rx_loc_abort;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event act=%h", a);
      end else begin
        e = exp_q.pop_front();
        chk("event", 64'(a), 64'(e));
      end
    end
  endtask

  // One nibble per 4 clocks; chk_lat pins the 1-cycle latency and 1-cycle strobe width.
  task automatic send_nib(input logic [3:0] n, input logic chk_lat, input logic [7:0] lat_byte);
    @(posedge clk); #1;
    bus.mesa_wi_nib_en = 1'b1;
    bus.mesa_wi_nib_d  = n;
    @(posedge clk); #1;
    bus.mesa_wi_nib_en = 1'b0;
    if (chk_lat) chk("latency_strobe", 64'({bus.mesa_wo_byte_en, bus.mesa_wo_byte_d}), 64'({1'b1, lat_byte}));
    @(posedge clk); #1;
    if (chk_lat) chk("strobe_width", 64'(bus.mesa_wo_byte_en), 64'(1'b0));
    @(posedge clk);
  endtask

  task automatic run_pkt(input logic [7:0] b[$], input int busy_idx, input int flush_at, input logic lat);
    model_pkt(b, busy_idx, (flush_at < 0) ? b.size() : flush_at);
    for (int i = 0; i < b.size(); i++) begin
      if (i == flush_at) begin
        @(posedge clk); #1;
        bus.mesa_wi_flush  = 1'b1;
        bus.mesa_wi_nib_en = 1'b1;
        bus.mesa_wi_nib_d  = b[i][7:4];
        @(posedge clk); #1;
        bus.mesa_wi_flush  = 1'b0;
        bus.mesa_wi_nib_en = 1'b0;
        repeat (2) @(posedge clk);
        break;
      end
      bus.mesa_wo_busy = (i == busy_idx);
      send_nib(b[i][7:4], 1'b0, 8'h00);
      send_nib(b[i][3:0], lat && (i == 0), b[i]);
      bus.mesa_wo_busy = 1'b0;
    end
    repeat (4) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.mesa_wi_flush  = 1'b0;
    bus.mesa_wi_nib_en = 1'b0;
    bus.mesa_wi_nib_d  = 4'h0;
    bus.mesa_wo_busy   = 1'b0;
    m_ovr = 1'b0; m_sub = 8'h00; m_len = 8'h00;
    reset_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", 64'({bus.mesa_wo_byte_en, bus.mesa_wo_byte_d, bus.wo_overrun, bus.rx_loc_start,
        bus.rx_loc_subslot, bus.rx_loc_len, bus.rx_byte_en, bus.rx_byte_d, bus.rx_loc_stop, bus.rx_loc_abort}), 64'd0);
    reset_n = 1'b1;

    pk = '{8'hF0, 8'h00, 8'h12, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    run_pkt(pk, -1, -1, 1'b1);
    chk("p1_hdr", 64'({bus.rx_loc_subslot, bus.rx_loc_len}), 64'(16'h1203));
    chk("p1_last", 64'({bus.rx_byte_d, bus.mesa_wo_byte_d}), 64'(16'hCCCC));

    pk = '{8'hF0, 8'h03, 8'h00, 8'h01, 8'h55};
    run_pkt(pk, -1, -1, 1'b0);
    chk("nonlocal_hold", 64'({bus.rx_loc_subslot, bus.rx_loc_len, bus.mesa_wo_byte_d}), 64'(24'h120355));

    pk = '{8'hF0, 8'hFF, 8'h20, 8'h00};
    run_pkt(pk, -1, -1, 1'b0);
    chk("bcast_hdr", 64'({bus.rx_loc_subslot, bus.rx_loc_len, bus.mesa_wo_byte_d}), 64'(24'h200000));

    send_nib(4'h5, 1'b0, 8'h00);
    pk = '{8'hF0, 8'h00, 8'h01, 8'h00};
    run_pkt(pk, -1, -1, 1'b0);
    chk("garbage_hdr", 64'({bus.rx_loc_subslot, bus.rx_loc_len}), 64'(16'h0100));

    pk = '{8'hF0, 8'h00, 8'h12, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    run_pkt(pk, -1, 5, 1'b0);
    pk = '{8'hF0, 8'h00, 8'h34, 8'h02, 8'h11, 8'h22};
    run_pkt(pk, -1, -1, 1'b0);
    chk("after_flush", 64'({bus.rx_loc_subslot, bus.rx_loc_len, bus.rx_byte_d}), 64'(24'h340222));

    pk = '{8'hF0, 8'h00, 8'h12, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    run_pkt(pk, 3, -1, 1'b0);
    chk("busy_overrun", 64'({bus.wo_overrun, bus.rx_byte_d}), 64'({1'b1, 8'hCC}));

    // Reset mid-packet: F0 is forwarded, then reset lands after the slot's high nibble.
    exp_q.push_back('{wo_en: 1'b1, wo_d: 8'hF0, ovr: m_ovr, start: 1'b0, sub: m_sub, len: m_len,
                      rx_en: 1'b0, rx_d: 8'h00, stop: 1'b0, abort: 1'b0});
    send_nib(4'hF, 1'b0, 8'h00);
    send_nib(4'h0, 1'b0, 8'h00);
    send_nib(4'h0, 1'b0, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b0;
    m_ovr = 1'b0; m_sub = 8'h00; m_len = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("midreset_outputs", 64'({bus.wo_overrun, bus.rx_loc_subslot, bus.rx_loc_len, bus.mesa_wo_byte_d}), 64'd0);
    reset_n = 1'b1;
    send_nib(4'h0, 1'b0, 8'h00);
    pk = '{8'hF0, 8'hFE, 8'h77, 8'h01, 8'h99};
    run_pkt(pk, -1, -1, 1'b0);
    pk = '{8'hF0, 8'h00, 8'hAB, 8'h01, 8'h5A};
    run_pkt(pk, -1, -1, 1'b0);
    chk("post_reset", 64'({bus.wo_overrun, bus.rx_loc_subslot, bus.rx_loc_len, bus.rx_byte_d}),
        64'({1'b0, 8'hAB, 8'h01, 8'h5A}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
